// File: rtl/trng_rs_sampler.sv
// RS-latch entropy sampler: excite/release/capture sequencing, XOR combining, repetition-count
// health test and word packing. Define TRNG_VN_EN to insert a von Neumann corrector on raw bits.
`timescale 1ns/1ps
module trng_rs_sampler #(
  parameter int N_CH       = 4,
  parameter int OUT_W      = 8,
  parameter int EXC_CYC    = 2,
  parameter int SETTLE_CYC = 3,
  parameter int REP_LIM    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [N_CH-1:0]  lat_r,
  output logic [N_CH-1:0]  lat_s,
  input  logic [N_CH-1:0]  lat_q,
  output logic [OUT_W-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             fault
);
  localparam int CNT_MAX = (EXC_CYC > SETTLE_CYC) ? EXC_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(OUT_W + 1);
  localparam int REP_W   = $clog2(REP_LIM + 1);

  typedef enum logic [1:0] {IDLE, EXCITE, RELEASE, CAPTURE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [N_CH-1:0]    sync_p0, sync_p1;
  logic               raw, cap, acc, acc_bit, trip, word_done;
  logic [REP_W-1:0]   rep_cnt, rep_nxt;
  logic               prev_raw;
  logic [BIT_W-1:0]   bit_cnt;
  logic [OUT_W-2:0]   shreg;
  logic [OUT_W-1:0]   data_nxt;

  function automatic logic [REP_W-1:0] rep_sat_inc(input logic [REP_W-1:0] c);
    if (c == REP_W'(REP_LIM)) return c;
    return c + REP_W'(1);
  endfunction

  // Stage p0/p1: two-flop synchroniser on the asynchronous latch outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= lat_q;
      sync_p1 <= sync_p0;
    end
  end

  assign raw = ^sync_p1;
  assign cap = (state == CAPTURE);

  // A zero run count means no previous raw bit exists yet
  always_comb begin
    rep_nxt = REP_W'(1);
    if (rep_cnt != '0 && raw == prev_raw) rep_nxt = rep_sat_inc(rep_cnt);
  end
  assign trip = cap && (rep_nxt == REP_W'(REP_LIM));

`ifdef TRNG_VN_EN
  logic vn_have, vn_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vn_have  <= 1'b0;
      vn_first <= 1'b0;
    end else if (cap) begin
      vn_have  <= ~vn_have;
      vn_first <= raw;
    end
  end

  assign acc     = cap && vn_have && (vn_first != raw);
  assign acc_bit = vn_first;
`else
  assign acc     = cap;
  assign acc_bit = raw;
`endif

  assign word_done = acc && (bit_cnt == BIT_W'(OUT_W - 1));
  assign data_nxt  = {shreg, acc_bit};

  // Partial-word shift register carries data only; bit_cnt decides validity
  always_ff @(posedge clk) begin
    if (acc) shreg <= data_nxt[OUT_W-2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      prev_raw  <= 1'b0;
      fault     <= 1'b0;
      bit_cnt   <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
    end else begin
      if (cap) begin
        prev_raw <= raw;
        rep_cnt  <= rep_nxt;
        if (trip) fault <= 1'b1;
      end
      if (rnd_valid && rnd_ready) rnd_valid <= 1'b0;
      if (acc) begin
        if (word_done) begin
          bit_cnt <= '0;
          // A word finishing on the tripping capture is dropped
          if (!trip && !fault) begin
            rnd_data  <= data_nxt;
            rnd_valid <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
      if (fault) rnd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && !rnd_valid && !fault) state_nxt = EXCITE;
      EXCITE:  if (cnt == CNT_W'(EXC_CYC - 1)) state_nxt = RELEASE;
      RELEASE: if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (en && !word_done && !trip && !fault) ? EXCITE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lat_r = '0;
    lat_s = '0;
    if (state == EXCITE) begin
      lat_r = '1;
      lat_s = '1;
    end
  end

endmodule

// File: tb/tb_trng_rs_sampler.sv
// Bench for trng_rs_sampler: random latch stimulus compared against a bit-list reference model
// of XOR combining, optional von Neumann correction, repetition health test and word packing.
`timescale 1ns/1ps
module tb_trng_rs_sampler;
  localparam int N_CH = 4, OUT_W = 8, EXC_CYC = 2, SETTLE_CYC = 3, REP_LIM = 32;
  localparam int PER = EXC_CYC + SETTLE_CYC + 1;

  logic clk = 1'b0;
  logic rst, en, rnd_ready, rnd_valid, fault;
  logic [N_CH-1:0] lat_r, lat_s, lat_q;
  logic [OUT_W-1:0] rnd_data;

  int checks = 0, failures = 0;
  logic [N_CH-1:0]  stim_q[$], applied_q[$];
  logic [OUT_W-1:0] got_q[$], exp_q[$];
  int exc_cnt, cyc, first_exc_cyc, first_vld_cyc, fault_exc, exp_fault_at;
  bit prev_exc, prev_vld, rand_ready;

  always #5 clk = ~clk;

  trng_rs_sampler #(.N_CH(N_CH), .OUT_W(OUT_W), .EXC_CYC(EXC_CYC),
                    .SETTLE_CYC(SETTLE_CYC), .REP_LIM(REP_LIM)) dut (
    .clk(clk), .rst(rst), .en(en), .lat_r(lat_r), .lat_s(lat_s), .lat_q(lat_q),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .fault(fault));

  function automatic logic [N_CH-1:0] with_parity(input bit p);
    logic [N_CH-1:0] v;
    v = N_CH'($urandom);
    if ((^v) != p) v[0] = ~v[0];
    return v;
  endfunction

  // Observe at the falling edge, then feed a new latch value at each excite start.
  task automatic drive_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (lat_r == '1 && !prev_exc) begin
        exc_cnt++;
        if (first_exc_cyc < 0) first_exc_cyc = cyc;
        lat_q = (stim_q.size() > 0) ? stim_q.pop_front() : N_CH'($urandom);
        applied_q.push_back(lat_q);
      end
      prev_exc = (lat_r == '1);
      if (rnd_valid && !prev_vld) begin
        got_q.push_back(rnd_data);
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      prev_vld = rnd_valid;
      if (fault && fault_exc < 0) fault_exc = exc_cnt;
      if (rand_ready) rnd_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; rnd_ready = 1'b0; lat_q = '0; rand_ready = 1'b0;
    stim_q.delete(); applied_q.delete(); got_q.delete(); exp_q.delete();
    exc_cnt = 0; cyc = 0; first_exc_cyc = -1; first_vld_cyc = -1; fault_exc = -1;
    prev_exc = 1'b0; prev_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference: walk the applied latch values as a plain list of raw bits.
  task automatic build_model();
    int run, nb;
    bit prevb, r, b, acc, trip, have, first;
    logic [OUT_W-1:0] word;
    run = 0; nb = 0; prevb = 0; have = 0; first = 0; word = '0;
    exp_q.delete(); exp_fault_at = -1;
    for (int i = 0; i < applied_q.size(); i++) begin
      r = ^applied_q[i];
      run = (i > 0 && r == prevb) ? run + 1 : 1;
      prevb = r;
      trip = (run >= REP_LIM);
`ifdef TRNG_VN_EN
      acc = 0; b = 0;
      if (!have) begin have = 1; first = r; end
      else begin
        have = 0;
        if (first != r) begin acc = 1; b = first; end
      end
`else
      acc = 1; b = r;
`endif
      if (acc) begin
        word = (word << 1) | OUT_W'(b);
        nb++;
        if (nb == OUT_W) begin
          if (!trip) exp_q.push_back(word);
          nb = 0; word = '0; have = 0;
        end
      end
      if (trip) begin exp_fault_at = i + 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rnd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); lat_q = N_CH'($urandom); end
    checks++; if (lat_r !== '0) begin failures++; $display("FAIL reset_lat_r got=%h exp=0", lat_r); end
    checks++; if (lat_s !== '0) begin failures++; $display("FAIL reset_lat_s got=%h exp=0", lat_s); end
    checks++; if (rnd_data !== '0) begin failures++; $display("FAIL reset_rnd_data got=%h exp=0", rnd_data); end
    checks++; if (rnd_valid !== 1'b0) begin failures++; $display("FAIL reset_rnd_valid got=%b exp=0", rnd_valid); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    en = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (lat_r !== '0) begin failures++; $display("FAIL idle_no_en got=%h exp=0", lat_r); end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (lat_r !== '1 || lat_s !== '1) begin
      failures++; $display("FAIL first_excite got_r=%h got_s=%h exp=%h", lat_r, lat_s, {N_CH{1'b1}});
    end
  endtask

`ifndef TRNG_VN_EN
  task automatic test_word();
    logic [7:0] pat;
    logic [OUT_W-1:0] d;
    do_reset();
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) stim_q.push_back(with_parity(pat[i]));
    en = 1'b1;
    drive_cycles(70);
    d = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL word_count got=%0d exp=1", got_q.size()); end
    checks++; if (d !== 8'hB2) begin failures++; $display("FAIL word_data got=%h exp=b2", d); end
    checks++;
    if (first_vld_cyc - first_exc_cyc + 1 != PER * OUT_W + 1) begin
      failures++; $display("FAIL word_latency got=%0d exp=%0d", first_vld_cyc - first_exc_cyc + 1, PER * OUT_W + 1);
    end
    checks++; if (rnd_valid !== 1'b1) begin failures++; $display("FAIL word_valid_held got=%b exp=1", rnd_valid); end
  endtask
`endif

  task automatic test_xor();
    int n;
    do_reset();
    for (int i = 0; i < 16; i++) begin stim_q.push_back(4'b0111); stim_q.push_back(4'b0101); end
    rnd_ready = 1'b1; en = 1'b1;
    drive_cycles(PER * 32 + 20);
    en = 1'b0;
    drive_cycles(30);
    build_model();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL xor_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL xor_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
`ifndef TRNG_VN_EN
    checks++; if (n == 0 || got_q[0] !== 8'hAA) begin failures++; $display("FAIL xor_first got=%h exp=aa", n ? got_q[0] : 'x); end
`endif
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] d0;
    int bad;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3000 && got_q.size() == 0; i++) drive_cycles(1);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL bp_word got=%0d exp=1", got_q.size()); end
    d0 = rnd_data; bad = 0;
    for (int i = 0; i < 100; i++) begin
      drive_cycles(1);
      if (rnd_data !== d0 || lat_r !== '0 || lat_s !== '0 || rnd_valid !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
    build_model();
    checks++;
    if (exp_q.size() == 0 || d0 !== exp_q[0]) begin
      failures++; $display("FAIL bp_data got=%h exp=%h", d0, exp_q.size() ? exp_q[0] : 'x);
    end
    rnd_ready = 1'b1;
    drive_cycles(1);
    checks++; if (rnd_valid !== 1'b0 || lat_r !== '0) begin failures++; $display("FAIL bp_valid_fall got_v=%b got_r=%h exp_v=0 exp_r=0", rnd_valid, lat_r); end
    drive_cycles(1);
    checks++; if (lat_r !== '1) begin failures++; $display("FAIL bp_resume got=%h exp=%h", lat_r, {N_CH{1'b1}}); end
  endtask

  task automatic test_en_drop();
    do_reset();
    rnd_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 200 && exc_cnt < 3; i++) drive_cycles(1);
    en = 1'b0;
    drive_cycles(30);
    checks++; if (exc_cnt != 3) begin failures++; $display("FAIL endrop_excites got=%0d exp=3", exc_cnt); end
    checks++; if (lat_r !== '0) begin failures++; $display("FAIL endrop_idle got=%h exp=0", lat_r); end
    en = 1'b1;
    for (int i = 0; i < 3000 && got_q.size() == 0; i++) drive_cycles(1);
    en = 1'b0;
    drive_cycles(30);
    build_model();
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0 || got_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL endrop_word got=%h exp=%h", got_q.size() ? got_q[0] : 'x, exp_q.size() ? exp_q[0] : 'x);
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    rand_ready = 1'b1; en = 1'b1;
    drive_cycles(3000);
    en = 1'b0; rand_ready = 1'b0; rnd_ready = 1'b1;
    drive_cycles(30);
    build_model();
    checks++; if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_fault();
    int bad, n;
    do_reset();
    for (int i = 0; i < 64; i++) stim_q.push_back(with_parity(1'b0));
    rnd_ready = 1'b1; en = 1'b1;
    drive_cycles(PER * REP_LIM + 60);
    build_model();
    checks++; if (fault_exc != REP_LIM || exp_fault_at != REP_LIM) begin failures++; $display("FAIL fault_at got=%0d exp=%0d", fault_exc, REP_LIM); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL fault_words got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fault_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      drive_cycles(1);
      if (rnd_valid !== 1'b0 || lat_r !== '0 || fault !== 1'b1) bad++;
    end
    checks++; if (bad != 0 || exc_cnt != REP_LIM) begin failures++; $display("FAIL fault_sticky bad_cycles=%0d excites=%0d exp=0,%0d", bad, exc_cnt, REP_LIM); end
    do_reset();
    @(negedge clk);
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b exp=0", fault); end
  endtask

`ifdef TRNG_VN_EN
  task automatic test_vn();
    bit raws[$] = '{0,1, 1,0, 0,0, 1,1, 1,0, 1,0, 0,1, 1,0, 0,1, 1,0};
    do_reset();
    foreach (raws[i]) stim_q.push_back(with_parity(raws[i]));
    rnd_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 3000 && got_q.size() == 0; i++) drive_cycles(1);
    build_model();
    checks++; if (got_q.size() == 0 || got_q[0] !== 8'h75) begin failures++; $display("FAIL vn_word got=%h exp=75", got_q.size() ? got_q[0] : 'x); end
    checks++; if (exp_q.size() == 0 || exp_q[0] !== 8'h75 || exc_cnt != raws.size()) begin failures++; $display("FAIL vn_excites got=%0d exp=%0d", exc_cnt, raws.size()); end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; rnd_ready = 1'b0; lat_q = '0; rand_ready = 1'b0;
    test_reset();
`ifndef TRNG_VN_EN
    test_word();
`endif
    test_xor();
    test_backpressure();
    test_en_drop();
    test_random();
    test_fault();
`ifdef TRNG_VN_EN
    test_vn();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
